// File: rtl/adc_capture_sequencer.sv
// -----------------------------------------------------------------------------
// adc_capture_sequencer
//
// Runs one ADC capture from START to completion. Samples arrive on an
// Avalon-ST sink (valid only, no backpressure) and go into a small FIFO. The
// FIFO head is written to consecutive SDRAM words through an Avalon-MM write
// master. The HPS configures and polls the block through an Avalon-MM slave.
//
// Handshakes:
//   Sink   : a sample transfers on any edge where streaming_sink_valid=1 and
//            the sequencer is willing to take it; otherwise it is lost.
//   Master : a beat transfers on an edge where master_write=1 and
//            master_waitrequest=0. While waitrequest is high, address, data
//            and write are held unchanged.
//   Slave  : zero-latency reads (readdata is combinational), single-cycle
//            writes; every access needs slave_chipselect.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   streaming_sink_*         sample input (data, valid)
//   slave_*                  register interface (address, chipselect, read,
//                            write, writedata, readdata)
//   master_*                 SDRAM write master (address, write, writedata,
//                            waitrequest)
//   irq                      done & IRQ_EN, level
//   busy                     high in CAPTURE or ABORT
//   dbg_state                current FSM state (0 IDLE, 1 CAPTURE, 2 ABORT)
//
// Register map (word index):
//   0 CTRL    b0 START (W1), b1 ABORT (W1), b2 IRQ_EN (R/W)
//   1 STATUS  b0 busy, b1 done, b2 overflow, b3 aborted; W1C on b1..b3
//   2 BASE    R/W, bits [1:0] forced to 0
//   3 COUNT   R/W
//   4 WRITTEN RO
// BASE and COUNT are frozen while busy. ADDR_W and CNT_W must be <= 32.
// -----------------------------------------------------------------------------
module adc_capture_sequencer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] streaming_sink_data,
  input  logic              streaming_sink_valid,
  input  logic [2:0]        slave_address,
  input  logic              slave_chipselect,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic [31:0]       slave_readdata,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  input  logic              master_waitrequest,
  output logic              irq,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ABORT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic               aborted_q, aborted_d;
  logic [31:0]        base_q, base_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   written_q, written_d;
  logic [CNT_W-1:0]   accepted_q, accepted_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               stall_q, stall_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

  logic               reg_wr;
  logic               ctrl_wr, status_wr, base_wr, count_wr;
  logic               start_req, abort_req;
  logic               fifo_empty, fifo_full;
  logic               mw, beat, push, want, room;
  logic [CNT_W-1:0]   written_inc;
  logic [DATA_W-1:0]  head_data;

  // Register write decode.
  assign reg_wr    = slave_chipselect & slave_write;
  assign ctrl_wr   = reg_wr && (slave_address == 3'd0);
  assign status_wr = reg_wr && (slave_address == 3'd1);
  assign base_wr   = reg_wr && (slave_address == 3'd2);
  assign count_wr  = reg_wr && (slave_address == 3'd3);
  assign start_req = ctrl_wr & slave_writedata[0];
  assign abort_req = ctrl_wr & slave_writedata[1];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_data  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign written_inc = written_q + CNT_W'(1);

  // A write that was stalled last cycle must be kept up until it completes,
  // which is what lets ABORT finish the in-flight beat and nothing more.
  assign stall_d = mw & master_waitrequest;

  always_comb begin
    state_d    = state_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q     & ~(status_wr & slave_writedata[1]);
    overflow_d = overflow_q & ~(status_wr & slave_writedata[2]);
    aborted_d  = aborted_q  & ~(status_wr & slave_writedata[3]);
    base_d     = base_q;
    count_d    = count_q;
    written_d  = written_q;
    accepted_d = accepted_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mw         = 1'b0;
    beat       = 1'b0;
    push       = 1'b0;
    want       = 1'b0;
    room       = 1'b0;

    if (ctrl_wr) irq_en_d = slave_writedata[2];

    if (state_q == ST_IDLE) begin
      if (base_wr)  base_d  = {slave_writedata[31:2], 2'b00};
      if (count_wr) count_d = slave_writedata[CNT_W-1:0];
    end

    // Hardware updates below are assigned after the W1C defaults, so a
    // hardware set beats a software clear in the same cycle.
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (count_q != '0) begin
            state_d    = ST_CAPTURE;
            written_d  = '0;
            accepted_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            done_d     = 1'b0;
            aborted_d  = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_CAPTURE: begin
        mw   = !fifo_empty;
        beat = mw && !master_waitrequest;
        // A pop on this edge frees a slot, so a full FIFO can still accept.
        room = !fifo_full || beat;
        want = streaming_sink_valid && (accepted_q < count_q) && !abort_req;
        if (want && room) begin
          push       = 1'b1;
          accepted_d = accepted_q + CNT_W'(1);
        end else if (want) begin
          overflow_d = 1'b1;
        end
        if (beat) begin
          rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
          written_d = written_inc;
        end
        // Finishing the final beat takes priority over a concurrent ABORT.
        if (beat && (written_inc == count_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (abort_req) begin
          state_d = ST_ABORT;
        end
      end

      ST_ABORT: begin
        mw   = stall_q;
        beat = mw && !master_waitrequest;
        if (beat) written_d = written_inc;
        if (!(mw && master_waitrequest)) begin
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          aborted_d = 1'b1;
          done_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      aborted_q  <= 1'b0;
      base_q     <= '0;
      count_q    <= '0;
      written_q  <= '0;
      accepted_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      aborted_q  <= aborted_d;
      base_q     <= base_d;
      count_q    <= count_d;
      written_q  <= written_d;
      accepted_q <= accepted_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stall_q    <= stall_d;
    end
  end

  // Storage has no reset; its contents are only visible through master_write.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q[PTR_W-1:0]] <= streaming_sink_data;
  end

  assign master_write     = mw;
  assign master_writedata = mw ? head_data : '0;
  assign master_address   = mw ? (ADDR_W'(base_q) + ADDR_W'({written_q, 2'b00}))
                               : '0;
  assign busy             = (state_q != ST_IDLE);
  assign irq              = done_q & irq_en_q;
  assign dbg_state        = state_q;

  always_comb begin
    slave_readdata = '0;
    if (slave_chipselect && slave_read) begin
      case (slave_address)
        3'd0:    slave_readdata = {29'd0, irq_en_q, 2'b00};
        3'd1:    slave_readdata = {28'd0, aborted_q, overflow_q, done_q, busy};
        3'd2:    slave_readdata = base_q;
        3'd3:    slave_readdata = 32'(count_q);
        3'd4:    slave_readdata = 32'(written_q);
        default: slave_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
module tb_adc_capture_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] sink_data = '0;
  logic        sink_valid = 1'b0;
  logic [2:0]  s_addr = '0;
  logic        s_cs = 1'b0;
  logic        s_rd = 1'b0;
  logic        s_wr = 1'b0;
  logic [31:0] s_wdata = '0;
  logic [31:0] s_rdata;
  logic [31:0] m_addr;
  logic        m_write;
  logic [31:0] m_wdata;
  logic        m_wait = 1'b0;
  logic        irq;
  logic        busy;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Beats seen on the master port, and the beats each test expects.
  logic [31:0] got_addr_q[$];
  logic [31:0] got_data_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_data_q[$];

  adc_capture_sequencer dut (
    .clk                  (clk),
    .reset                (reset),
    .streaming_sink_data  (sink_data),
    .streaming_sink_valid (sink_valid),
    .slave_address        (s_addr),
    .slave_chipselect     (s_cs),
    .slave_read           (s_rd),
    .slave_write          (s_wr),
    .slave_writedata      (s_wdata),
    .slave_readdata       (s_rdata),
    .master_address       (m_addr),
    .master_write         (m_write),
    .master_writedata     (m_wdata),
    .master_waitrequest   (m_wait),
    .irq                  (irq),
    .busy                 (busy),
    .dbg_state            (dbg_state)
  );

  // Clock and beat monitor (sampled mid-cycle, away from the active edge).
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && m_write && !m_wait) begin
      got_addr_q.push_back(m_addr);
      got_data_q.push_back(m_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    s_addr = a; s_wdata = d; s_cs = 1'b1; s_wr = 1'b1;
    tick();
    s_cs = 1'b0; s_wr = 1'b0; s_wdata = '0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    s_addr = a; s_cs = 1'b1; s_rd = 1'b1;
    #1;
    d = s_rdata;
    s_cs = 1'b0; s_rd = 1'b0;
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && busy; k++) tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic clear_mon();
    got_addr_q.delete(); got_data_q.delete();
    exp_q.delete(); exp_data_q.delete();
  endtask

  task automatic check_beats(input string name);
    tests_run++;
    if (got_addr_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d beats required %0d", name, got_addr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_addr_q[i] !== exp_q[i] || got_data_q[i] !== exp_data_q[i]) begin
          tests_failed++;
          $display("FAIL %s_beat%0d: got addr %h data %h required addr %h data %h",
                   name, i, got_addr_q[i], got_data_q[i], exp_q[i], exp_data_q[i]);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests_run++;
    if (m_write !== 1'b0 || irq !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: write=%b irq=%b busy=%b state=%0d required 0 0 0 0",
               m_write, irq, busy, dbg_state);
    end
    for (int a = 0; a < 6; a++) begin
      reg_read(3'(a), rd);
      tests_run++;
      if (rd !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_reg%0d: got %h required 00000000", a, rd);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    clear_mon();
    reg_write(3'd2, 32'h1000_0000);
    reg_write(3'd3, 32'd4);
    reg_write(3'd0, 32'h5);
    for (int i = 0; i < 4; i++) begin
      sink_valid = 1'b1; sink_data = 32'hA0 + 32'(i);
      exp_q.push_back(32'h1000_0000 + 32'(4 * i));
      exp_data_q.push_back(32'hA0 + 32'(i));
      tick();
      if (i == 0) begin
        tests_run++;
        if (m_write !== 1'b1 || m_addr !== 32'h1000_0000 || m_wdata !== 32'hA0) begin
          tests_failed++;
          $display("FAIL basic_latency: write=%b addr=%h data=%h required 1 10000000 000000a0",
                   m_write, m_addr, m_wdata);
        end
      end
    end
    sink_valid = 1'b0;
    wait_idle("basic");
    check_beats("basic");
    reg_read(3'd4, rd);
    tests_run++;
    if (rd !== 32'd4) begin tests_failed++; $display("FAIL basic_written: got %h required 4", rd); end
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 32'h2) begin tests_failed++; $display("FAIL basic_status: got %h required 2", rd); end
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL basic_irq: got %b required 1", irq); end
    reg_write(3'd1, 32'h2);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL basic_irq_clear: got %b required 0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int unstable;
    clear_mon();
    unstable = 0;
    reg_write(3'd2, 32'h2000_0000);
    reg_write(3'd3, 32'd20);
    reg_write(3'd0, 32'h1);
    // Samples 0..15 fill the FIFO, 16..29 are dropped; once waitrequest
    // drops at sample 30, samples 30..33 ride in on the pops.
    for (int i = 0; i < 60; i++) begin
      sink_valid = 1'b1; sink_data = 32'hB00 + 32'(i);
      m_wait = (i < 30);
      tick();
      if (i < 30 && (m_write !== 1'b1 || m_addr !== 32'h2000_0000 || m_wdata !== 32'hB00))
        unstable++;
    end
    sink_valid = 1'b0; m_wait = 1'b0;
    tests_run++;
    if (unstable != 0) begin
      tests_failed++;
      $display("FAIL ovf_hold: %0d unstable cycles required 0", unstable);
    end
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(32'h2000_0000 + 32'(4 * i));
      exp_data_q.push_back((i < 16) ? 32'hB00 + 32'(i) : 32'hB1E + 32'(i - 16));
    end
    wait_idle("ovf");
    check_beats("ovf");
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 32'h6) begin tests_failed++; $display("FAIL ovf_status: got %h required 6", rd); end
    reg_read(3'd4, rd);
    tests_run++;
    if (rd !== 32'd20) begin tests_failed++; $display("FAIL ovf_written: got %h required 14", rd); end
    reg_write(3'd1, 32'hE);
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("FAIL ovf_w1c: got %h required 0", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int held;
    clear_mon();
    held = 0;
    reg_write(3'd2, 32'h3000_0000);
    reg_write(3'd3, 32'd100);
    reg_write(3'd0, 32'h1);
    // Beats 0..9 complete on edges 1..10; beat 10 stalls from edge 11.
    for (int i = 0; i < 15; i++) begin
      sink_valid = 1'b1; sink_data = 32'hC00 + 32'(i);
      m_wait = (i >= 11);
      tick();
    end
    reg_write(3'd0, 32'h2);
    for (int i = 0; i < 3; i++) begin
      if (busy === 1'b1 && m_write === 1'b1 && m_addr === 32'h3000_0028) held++;
      tick();
    end
    tests_run++;
    if (held != 3) begin tests_failed++; $display("FAIL abort_hold: held %0d cycles required 3", held); end
    m_wait = 1'b0;
    tick();
    sink_valid = 1'b0;
    tick();
    tests_run++;
    if (m_write !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_stop: write=%b busy=%b required 0 0", m_write, busy);
    end
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(32'h3000_0000 + 32'(4 * i));
      exp_data_q.push_back(32'hC00 + 32'(i));
    end
    check_beats("abort");
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 32'h8) begin tests_failed++; $display("FAIL abort_status: got %h required 8", rd); end
    reg_read(3'd4, rd);
    tests_run++;
    if (rd !== 32'd11) begin tests_failed++; $display("FAIL abort_written: got %h required b", rd); end
    reg_write(3'd1, 32'h8);
  endtask

  task automatic test_edges();
    logic [31:0] rd;
    clear_mon();
    // COUNT=0: done next cycle, no master activity.
    reg_write(3'd3, 32'd0);
    reg_write(3'd0, 32'h1);
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 32'h2 || got_addr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_count: status=%h beats=%0d required 2 0", rd, got_addr_q.size());
    end
    reg_write(3'd1, 32'h2);
    // ABORT in IDLE is ignored.
    reg_write(3'd0, 32'h2);
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("FAIL idle_abort: got %h required 0", rd); end
    // Wrapping base, low address bits forced to zero.
    reg_write(3'd2, 32'hFFFF_FFFB);
    reg_read(3'd2, rd);
    tests_run++;
    if (rd !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL base_lsb: got %h required fffffff8", rd); end
    reg_write(3'd3, 32'd4);
    reg_write(3'd0, 32'h1);
    // START and config writes while busy have no effect.
    reg_write(3'd3, 32'd8);
    reg_write(3'd2, 32'h5000_0000);
    reg_write(3'd0, 32'h1);
    reg_read(3'd3, rd);
    tests_run++;
    if (rd !== 32'd4) begin tests_failed++; $display("FAIL busy_count: got %h required 4", rd); end
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 32'h1) begin tests_failed++; $display("FAIL busy_status: got %h required 1", rd); end
    for (int i = 0; i < 4; i++) begin
      sink_valid = 1'b1; sink_data = 32'hD0 + 32'(i);
      exp_data_q.push_back(32'hD0 + 32'(i));
      tick();
    end
    sink_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
    wait_idle("wrap");
    check_beats("wrap");
    reg_write(3'd1, 32'hE);
  endtask

  task automatic test_reset_midrun();
    logic [31:0] rd;
    clear_mon();
    reg_write(3'd2, 32'h4000_0000);
    reg_write(3'd3, 32'd8);
    reg_write(3'd0, 32'h5);
    m_wait = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sink_valid = 1'b1; sink_data = 32'hE00 + 32'(i);
      tick();
    end
    sink_valid = 1'b0;
    reset = 1'b1;
    tick();
    tests_run++;
    if (m_write !== 1'b0 || irq !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_out: write=%b irq=%b busy=%b required 0 0 0", m_write, irq, busy);
    end
    reset = 1'b0;
    m_wait = 1'b0;
    for (int a = 0; a < 5; a++) begin
      reg_read(3'(a), rd);
      tests_run++;
      if (rd !== 32'h0) begin tests_failed++; $display("FAIL midreset_reg%0d: got %h required 0", a, rd); end
    end
    clear_mon();
    reg_write(3'd2, 32'h0000_0100);
    reg_write(3'd3, 32'd2);
    reg_write(3'd0, 32'h1);
    for (int i = 0; i < 2; i++) begin
      sink_valid = 1'b1; sink_data = 32'hE0 + 32'(i);
      exp_q.push_back(32'h100 + 32'(4 * i));
      exp_data_q.push_back(32'hE0 + 32'(i));
      tick();
    end
    sink_valid = 1'b0;
    wait_idle("rerun");
    check_beats("rerun");
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 32'h2) begin tests_failed++; $display("FAIL rerun_status: got %h required 2", rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_abort();
    test_edges();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
